// File: rtl/instruction_fetch_pkg.sv
// Shared core definitions for the fetch stage: state encoding and instruction constants.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding
    S_HOLD  = 2'd1,  // instruction presented to consumer
    S_DROP  = 2'd2   // wrong-path request outstanding, response will be discarded
  } fetchState_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, consumer handshake and redirect path.
interface instruction_fetch_if #(
  parameter int unsigned PC_WIDTH = 8
);
  import instruction_fetch_pkg::*;

  logic                   oIMEM_REQ;
  logic [PC_WIDTH-1:0]    oIMEM_ADDR;
  logic                   iIMEM_ACK;
  logic [INSTR_WIDTH-1:0] iIMEM_DATA;
  logic                   oVALID;
  logic                   iREADY;
  logic [INSTR_WIDTH-1:0] oIR;
  logic [PC_WIDTH-1:0]    oPC;
  logic                   iREDIRECT;
  logic [PC_WIDTH-1:0]    iREDIRECT_PC;
  logic                   oMISALIGN;

  modport master (
    output oIMEM_REQ, oIMEM_ADDR, oVALID, oIR, oPC, oMISALIGN,
    input  iIMEM_ACK, iIMEM_DATA, iREADY, iREDIRECT, iREDIRECT_PC
  );

  modport slave (
    input  oIMEM_REQ, oIMEM_ADDR, oVALID, oIR, oPC, oMISALIGN,
    output iIMEM_ACK, iIMEM_DATA, iREADY, iREDIRECT, iREDIRECT_PC
  );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight, and
// presents each fetched word with its address until the consumer takes it.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic                 iCLK,
  input logic                 iRST,
  instruction_fetch_if.master bus
);

  fetchState_t            state, stateNext;
  logic [PC_WIDTH-1:0]    pc, pcNext;
  logic [PC_WIDTH-1:0]    addr, addrNext;
  logic [PC_WIDTH-1:0]    opc, opcNext;
  logic [INSTR_WIDTH-1:0] ir, irNext;
  logic                   req, reqNext;
  logic                   valid, validNext;
  logic                   misalign, misalignNext;

  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    pcInc;
  logic                   memDone;

  assign target  = {bus.iREDIRECT_PC[PC_WIDTH-1:2], 2'b00};
  assign pcInc   = pc + PC_WIDTH'(4);
  assign memDone = req & bus.iIMEM_ACK;

  // NOTE: every next-value gets a default before the case, so no path can infer a latch.
  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    addrNext     = addr;
    opcNext      = opc;
    irNext       = ir;
    reqNext      = req;
    validNext    = valid;
    misalignNext = bus.iREDIRECT & (|bus.iREDIRECT_PC[1:0]);

    unique case (state)
      S_FETCH: begin
        if (bus.iREDIRECT) begin
          pcNext = target;
          if (req && !bus.iIMEM_ACK) begin
            // The old address must stay on the bus until memory completes it.
            stateNext = S_DROP;
          end else begin
            reqNext  = 1'b1;
            addrNext = target;
          end
        end else if (!req) begin
          reqNext  = 1'b1;
          addrNext = pc;
        end else if (memDone) begin
          irNext    = bus.iIMEM_DATA;
          opcNext   = pc;
          validNext = 1'b1;
          reqNext   = 1'b0;
          stateNext = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.iREDIRECT) begin
          validNext = 1'b0;
          pcNext    = target;
          reqNext   = 1'b1;
          addrNext  = target;
          stateNext = S_FETCH;
        end else if (bus.iREADY) begin
          validNext = 1'b0;
          pcNext    = pcInc;
          reqNext   = 1'b1;
          addrNext  = pcInc;
          stateNext = S_FETCH;
        end
      end

      S_DROP: begin
        if (bus.iREDIRECT) pcNext = target;
        if (memDone) begin
          addrNext  = bus.iREDIRECT ? target : pc;
          stateNext = S_FETCH;
        end
      end

      default: stateNext = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      addr     <= RESET_PC;
      opc      <= RESET_PC;
      ir       <= NOP;
      req      <= 1'b0;
      valid    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      addr     <= addrNext;
      opc      <= opcNext;
      ir       <= irNext;
      req      <= reqNext;
      valid    <= validNext;
      misalign <= misalignNext;
    end
  end

  assign bus.oIMEM_REQ  = req;
  assign bus.oIMEM_ADDR = addr;
  assign bus.oVALID     = valid;
  assign bus.oIR        = ir;
  assign bus.oPC        = opc;
  assign bus.oMISALIGN  = misalign;

endmodule
